// File: rtl/child_slot_arbiter_if.sv
// child_slot_arbiter_if: request/grant bundle between the five children and
// the slot arbiter.
//   req     : per-child level request (driven by the children, master side)
//   gnt     : one-hot registered grant (driven by the arbiter, slave side)
//   gnt_id  : index of the current owner, meaningful only while busy=1
//   busy    : a grant is active
//   timeout : one-cycle pulse when the watchdog revokes an owner
interface child_slot_arbiter_if #(
  parameter int NUM_REQ = 5
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [2:0]         gnt_id;
  logic               busy;
  logic               timeout;

  modport master (output req, input gnt, gnt_id, busy, timeout);
  modport slave  (input req, output gnt, gnt_id, busy, timeout);
endinterface

// File: rtl/child_slot_arbiter.sv
// child_slot_arbiter: round-robin owner of one shared execution slot.
// A child keeps the slot while it holds req; every handoff passes through
// a one-cycle GAP with no grant.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : child_slot_arbiter_if.slave (req in; gnt, gnt_id, busy, timeout out)
// Optional macro CHILD_ARB_WATCHDOG_EN adds a hold-time watchdog: an owner
// still requesting after HOLD_MAX grant cycles is revoked, pulses timeout and
// is masked until it drops req. Without it timeout is tied low.
module child_slot_arbiter #(
  parameter int NUM_REQ  = 5,
  parameter int HOLD_MAX = 16
) (
  input logic              clk,
  input logic              rst_n,
  child_slot_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  localparam logic [2:0] PTR_RST = 3'(NUM_REQ - 1);

  state_t             state, state_nx;
  logic [NUM_REQ-1:0] gnt;
  logic [2:0]         gnt_id;
  logic               busy;
  logic [2:0]         ptr;
  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] cand, rot;
  logic [3:0]         off, sum;
  logic               sel_found;
  logic [2:0]         sel_idx;
  logic               owner_req, hold_expired;
  logic               do_grant, do_release, do_revoke;

  assign bus.gnt    = gnt;
  assign bus.gnt_id = gnt_id;
  assign bus.busy   = busy;

  // gnt is one-hot and registered, so it picks out the owner's request bit.
  assign owner_req = |(bus.req & gnt);

  // Circular search from ptr+1: rotate the doubled candidate vector so the
  // first position after the last owner lands at bit 0, then take the
  // lowest set bit and map it back.
  always_comb begin
    cand = bus.req & ~mask;
    rot  = NUM_REQ'({cand, cand} >> ({1'b0, ptr} + 4'd1));
    off  = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--)
      if (rot[j]) off = 4'(j);
    sel_found = |cand;
    sum = {1'b0, ptr} + 4'd1 + off;
    if (sum >= 4'(NUM_REQ)) sum = sum - 4'(NUM_REQ);
    sel_idx = 3'(sum);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    do_grant   = 1'b0;
    do_release = 1'b0;
    do_revoke  = 1'b0;
    case (state)
      IDLE:  if (sel_found) begin
               do_grant = 1'b1;
               state_nx = GRANT;
             end
      GRANT: if (!owner_req) begin
               do_release = 1'b1;
               state_nx   = GAP;
             end else if (hold_expired) begin
               do_revoke = 1'b1;
               state_nx  = GAP;
             end
      GAP:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt    <= '0;
      gnt_id <= '0;
      busy   <= 1'b0;
      ptr    <= PTR_RST;
    end else if (do_grant) begin
      gnt    <= NUM_REQ'(1) << sel_idx;
      gnt_id <= sel_idx;
      ptr    <= sel_idx;
      busy   <= 1'b1;
    end else if (do_release || do_revoke) begin
      gnt  <= '0;
      busy <= 1'b0;
    end
  end

`ifdef CHILD_ARB_WATCHDOG_EN
  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(HOLD_MAX);

  logic [HW-1:0] hold_cnt;
  logic          timeout;

  // hold_cnt reads k-1 in the k-th grant cycle, so the revoke decided at
  // HOLD_LAST leaves gnt high for exactly HOLD_MAX cycles.
  assign hold_expired = (hold_cnt == HOLD_LAST);
  assign bus.timeout  = timeout;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      mask     <= '0;
      timeout  <= 1'b0;
    end else begin
      timeout <= do_revoke;
      // A revoked child stays masked until it lets go of req.
      mask    <= (mask & bus.req) | (do_revoke ? gnt : '0);
      if (do_grant)
        hold_cnt <= '0;
      else if (state == GRANT && hold_cnt != HOLD_SAT)
        hold_cnt <= hold_cnt + HW'(1);
    end
  end
`else
  assign hold_expired = 1'b0;
  assign mask         = '0;
  assign bus.timeout  = 1'b0;
`endif
endmodule

// File: tb/tb_child_slot_arbiter.sv
// Directed bench for child_slot_arbiter: reset, single owner, round-robin
// order with GAP bubbles, circular search, non-latching of requests, reset
// during a grant, and hold-time behaviour with or without the watchdog.
module tb_child_slot_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  child_slot_arbiter_if #(.NUM_REQ(5)) bus ();

  child_slot_arbiter #(.NUM_REQ(5), .HOLD_MAX(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    bus.req = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.req = 5'b11111;
    tick();
    tick();
    checks++; if (bus.gnt !== 5'b0) begin errors++; $display("FAIL reset_gnt got %b exp 00000", bus.gnt); end
    checks++; if (bus.gnt_id !== 3'd0) begin errors++; $display("FAIL reset_gnt_id got %0d exp 0", bus.gnt_id); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
    checks++; if (bus.timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", bus.timeout); end
    bus.req = '0;
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_single;
    int busy_cnt;
    busy_cnt = 0;
    bus.req = 5'b00001;
    tick();
    checks++; if (bus.gnt !== 5'b00001) begin errors++; $display("FAIL single_gnt got %b exp 00001", bus.gnt); end
    checks++; if (bus.gnt_id !== 3'd0) begin errors++; $display("FAIL single_gnt_id got %0d exp 0", bus.gnt_id); end
    for (int i = 0; i < 6; i++) begin
      if (bus.busy) busy_cnt++;
      if (i == 3) bus.req = '0;
      tick();
    end
    checks++; if (busy_cnt !== 4) begin errors++; $display("FAIL single_busy_cycles got %0d exp 4", busy_cnt); end
    checks++; if (bus.gnt !== 5'b0) begin errors++; $display("FAIL single_release_gnt got %b exp 00000", bus.gnt); end
  endtask

  task automatic test_round_robin;
    logic [4:0] e;
    int low;
    do_reset();
    bus.req = 5'b11111;
    tick();
    for (int k = 0; k < 6; k++) begin
      e = 5'b00001 << (k % 5);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rr_busy[%0d] got %b exp 1", k, bus.busy); end
      checks++; if (bus.gnt_id !== 3'(k % 5)) begin errors++; $display("FAIL rr_gnt_id[%0d] got %0d exp %0d", k, bus.gnt_id, k % 5); end
      checks++; if (bus.gnt !== e) begin errors++; $display("FAIL rr_gnt[%0d] got %b exp %b", k, bus.gnt, e); end
      if (k == 5) break;
      tick();
      tick();
      bus.req = bus.req & ~e;
      low = 0;
      for (int t = 0; t < 8; t++) begin
        tick();
        if (t == 0) bus.req = 5'b11111;
        if (bus.busy) break;
        low++;
      end
      checks++; if (low !== 2) begin errors++; $display("FAIL rr_gap[%0d] got %0d idle cycles exp 2", k, low); end
    end
    bus.req = '0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_circular;
    do_reset();
    bus.req = 5'b00100;
    tick();
    checks++; if (bus.gnt_id !== 3'd2) begin errors++; $display("FAIL circ_first got %0d exp 2", bus.gnt_id); end
    bus.req = '0;
    tick();
    tick();
    bus.req = 5'b10100;
    tick();
    checks++; if (bus.gnt_id !== 3'd4) begin errors++; $display("FAIL circ_gnt_id got %0d exp 4", bus.gnt_id); end
    checks++; if (bus.gnt !== 5'b10000) begin errors++; $display("FAIL circ_gnt got %b exp 10000", bus.gnt); end
  endtask

  // Owner 4 releases while 0 raises a short request that drops during GAP:
  // it must not be remembered.
  task automatic test_no_latch;
    bus.req = 5'b00001;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL nolatch_gap_busy got %b exp 0", bus.busy); end
    bus.req = '0;
    tick();
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL nolatch_busy got %b exp 0", bus.busy); end
    checks++; if (bus.gnt !== 5'b0) begin errors++; $display("FAIL nolatch_gnt got %b exp 00000", bus.gnt); end
  endtask

  task automatic test_reset_mid_grant;
    do_reset();
    bus.req = 5'b01000;
    tick();
    checks++; if (bus.gnt_id !== 3'd3) begin errors++; $display("FAIL rmid_pre got %0d exp 3", bus.gnt_id); end
    tick();
    rst_n = 1'b0;
    tick();
    checks++; if (bus.gnt !== 5'b0) begin errors++; $display("FAIL rmid_gnt got %b exp 00000", bus.gnt); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", bus.busy); end
    checks++; if (bus.gnt_id !== 3'd0) begin errors++; $display("FAIL rmid_gnt_id got %0d exp 0", bus.gnt_id); end
    rst_n = 1'b1;
    tick();
    checks++; if (bus.gnt_id !== 3'd3) begin errors++; $display("FAIL rmid_regrant_id got %0d exp 3", bus.gnt_id); end
    checks++; if (bus.gnt !== 5'b01000) begin errors++; $display("FAIL rmid_regrant_gnt got %b exp 01000", bus.gnt); end
    bus.req = '0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_hold;
    int gcnt, to_cnt, to_at;
    gcnt = 0;
    to_cnt = 0;
    to_at = -1;
    do_reset();
    bus.req = 5'b00010;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (bus.gnt[1]) gcnt++;
      if (bus.timeout) begin to_cnt++; to_at = i; end
    end
`ifdef CHILD_ARB_WATCHDOG_EN
    checks++; if (gcnt !== 16) begin errors++; $display("FAIL wd_gnt_cycles got %0d exp 16", gcnt); end
    checks++; if (to_cnt !== 1) begin errors++; $display("FAIL wd_timeout_count got %0d exp 1", to_cnt); end
    checks++; if (to_at !== 17) begin errors++; $display("FAIL wd_timeout_cycle got %0d exp 17", to_at); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL wd_masked_busy got %b exp 0", bus.busy); end
    bus.req = '0;
    tick();
    bus.req = 5'b00010;
    tick();
    checks++; if (bus.gnt !== 5'b00010) begin errors++; $display("FAIL wd_regrant got %b exp 00010", bus.gnt); end
`else
    checks++; if (gcnt !== 30) begin errors++; $display("FAIL hold_gnt_cycles got %0d exp 30", gcnt); end
    checks++; if (to_cnt !== 0) begin errors++; $display("FAIL hold_timeout_count got %0d exp 0", to_cnt); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL hold_busy got %b exp 1", bus.busy); end
`endif
    bus.req = '0;
    tick();
    tick();
    tick();
  endtask

  initial begin
    bus.req = '0;
    tick();
    test_reset();
    test_single();
    test_round_robin();
    test_circular();
    test_no_latch();
    test_reset_mid_grant();
    test_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
